// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit (IF/ID/EX/MEM/WB) driving per-state
// datapath controls, with ready handshakes to instruction/data memory and a
// handshake timeout that raises a one-cycle bus_err and retries the request.
// Optional build macro: MC_CTRL_ILLEGAL_TRAP_EN. When it is defined, an
// undefined opcode or funct parks the FSM in TRAP until reset. When it is not
// defined, an undefined instruction is treated as a NOP.
// Handshake: a request (imem_req/dmem_req) is held high in its state until the
// matching ready is seen in the same cycle; ready outside IF/MEM is ignored.
module mc_ctrl #(
    parameter int ALU_CTR_W = 3,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 alu_zero,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           npc_sel,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic                 alu_src,
    output logic [1:0]           ext_op,
    output logic [1:0]           mem_to_reg,
    output logic [ALU_CTR_W-1:0] alu_ctr,
    output logic                 bus_err,
    output logic [2:0]           state
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [ALU_CTR_W-1:0] ALU_ADDU = ALU_CTR_W'(0);
    localparam logic [ALU_CTR_W-1:0] ALU_SUBU = ALU_CTR_W'(1);
    localparam logic [ALU_CTR_W-1:0] ALU_OR   = ALU_CTR_W'(2);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_hit, timeout;

    // Instruction decode (only meaningful from ID onward).
    logic [5:0] op, funct;
    logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic       is_lw, is_sw, is_beq, is_j, is_jal, is_legal;
    logic       unused_instr;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];
    assign is_r     = (op == 6'b000000);
    assign is_addu  = is_r && (funct == 6'b100001);
    assign is_subu  = is_r && (funct == 6'b100011);
    assign is_jr    = is_r && (funct == 6'b001000);
    assign is_ori   = (op == 6'b001101);
    assign is_lui   = (op == 6'b001111);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);
    assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_j | is_jal;

    // A wait cycle is an IF/MEM cycle without its ready; the last allowed one times out.
    assign wait_hit = ((state_q == S_IF)  && !imem_ready) ||
                      ((state_q == S_MEM) && !dmem_ready);
    assign timeout  = wait_hit && (wait_cnt == CNT_W'(WAIT_MAX - 1));
    assign state    = state_q;

    // State register, asynchronously returned to IF on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IF;
        else        state_q <= state_d;
    end

    // Wait counter: counts consecutive wait cycles, clears on ready, state change or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    wait_cnt <= '0;
        else if (wait_hit && !timeout) wait_cnt <= wait_cnt + 1'b1;
        else                           wait_cnt <= '0;
    end

    // Next state and per-state datapath controls; everything is held at 0 in reset.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        npc_sel    = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        alu_src    = 1'b0;
        ext_op     = 2'd0;
        mem_to_reg = 2'd0;
        alu_ctr    = ALU_ADDU;
        bus_err    = 1'b0;
        if (rst_n) begin
            bus_err = timeout;
            // ALU/extender selects are held through EX, MEM and WB so the datapath stays stable.
            if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
                if (is_subu) alu_ctr = ALU_SUBU;
                if (is_ori) begin
                    alu_src = 1'b1; ext_op = 2'd0; alu_ctr = ALU_OR;
                end
                if (is_lui) begin
                    alu_src = 1'b1; ext_op = 2'd2; alu_ctr = ALU_OR;
                end
                if (is_lw || is_sw) begin
                    alu_src = 1'b1; ext_op = 2'd1; alu_ctr = ALU_ADDU;
                end
                if (is_beq) begin
                    ext_op = 2'd1; alu_ctr = ALU_SUBU;
                end
            end
            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    if (is_j || is_jal) begin
                        pc_write = 1'b1;
                        npc_sel  = 2'd2;
                        state_d  = S_IF;
                        if (is_jal) begin
                            reg_write  = 1'b1;
                            reg_dst    = 2'd2;
                            mem_to_reg = 2'd2;
                        end
                    end else if (is_jr) begin
                        pc_write = 1'b1;
                        npc_sel  = 2'd3;
                        state_d  = S_IF;
                    end else if (is_legal) begin
                        state_d = S_EX;
                    end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_IF;
`endif
                    end
                end
                S_EX: begin
                    if (is_beq) begin
                        npc_sel  = 2'd1;
                        pc_write = alu_zero;
                        state_d  = S_IF;
                    end else if (is_lw || is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_write = is_sw;
                    if (dmem_ready) state_d = is_lw ? S_WB : S_IF;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_r  ? 2'd1 : 2'd0;
                    mem_to_reg = is_lw ? 2'd1 : 2'd0;
                    state_d    = S_IF;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_TRAP: state_d = S_TRAP;
`endif
                default: state_d = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_mc_ctrl;

    localparam logic [31:0] I_ADDU = 32'h0022_1821;
    localparam logic [31:0] I_SUBU = 32'h0022_1823;
    localparam logic [31:0] I_ORI  = 32'h3422_0005;
    localparam logic [31:0] I_LUI  = 32'h3C01_0001;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    logic        clk, rst_n;
    logic [31:0] instr;
    logic        alu_zero, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, mem_write, ir_write, pc_write;
    logic [1:0]  npc_sel, reg_dst, ext_op, mem_to_reg;
    logic        reg_write, alu_src, bus_err;
    logic [2:0]  alu_ctr;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    mc_ctrl #(.ALU_CTR_W(3), .WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .npc_sel(npc_sel),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .ext_op(ext_op), .mem_to_reg(mem_to_reg), .alu_ctr(alu_ctr),
        .bus_err(bus_err), .state(state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the falling edge.
    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    // IF cycle with imem_ready high: fetch completes and the FSM moves on to ID.
    task automatic do_fetch(input logic [31:0] ins);
        instr = ins;
        imem_ready = 1'b1;
        #1;
        check_eq("if_state", 32'(state), 32'd0);
        check_eq("if_ir_write", 32'(ir_write), 32'd1);
        check_eq("if_pc_write", 32'(pc_write), 32'd1);
        check_eq("if_npc_sel", 32'(npc_sel), 32'd0);
        nc();
    endtask

    initial begin
        rst_n = 1'b0; instr = I_ADDU; alu_zero = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_ir_write", 32'(ir_write), 32'd0);
        check_eq("rst_pc_write", 32'(pc_write), 32'd0);
        check_eq("rst_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // addu: IF, ID, EX, WB
        do_fetch(I_ADDU);
        check_eq("addu_id_state", 32'(state), 32'd1);
        check_eq("addu_id_pc_write", 32'(pc_write), 32'd0);
        nc();
        check_eq("addu_ex_state", 32'(state), 32'd2);
        check_eq("addu_ex_alu_src", 32'(alu_src), 32'd0);
        check_eq("addu_ex_reg_write", 32'(reg_write), 32'd0);
        nc();
        check_eq("addu_wb_state", 32'(state), 32'd4);
        check_eq("addu_wb_reg_write", 32'(reg_write), 32'd1);
        check_eq("addu_wb_reg_dst", 32'(reg_dst), 32'd1);
        check_eq("addu_wb_alu_ctr", 32'(alu_ctr), 32'd0);
        nc();
        check_eq("addu_done_state", 32'(state), 32'd0);

        // subu
        do_fetch(I_SUBU);
        nc();
        check_eq("subu_ex_alu_ctr", 32'(alu_ctr), 32'd1);
        nc();
        check_eq("subu_wb_alu_ctr", 32'(alu_ctr), 32'd1);
        check_eq("subu_wb_mem_to_reg", 32'(mem_to_reg), 32'd0);
        nc();

        // ori
        do_fetch(I_ORI);
        nc();
        check_eq("ori_ex_alu_src", 32'(alu_src), 32'd1);
        check_eq("ori_ex_ext_op", 32'(ext_op), 32'd0);
        check_eq("ori_ex_alu_ctr", 32'(alu_ctr), 32'd2);
        nc();
        check_eq("ori_wb_reg_dst", 32'(reg_dst), 32'd0);
        check_eq("ori_wb_reg_write", 32'(reg_write), 32'd1);
        nc();

        // lui
        do_fetch(I_LUI);
        nc();
        check_eq("lui_ex_ext_op", 32'(ext_op), 32'd2);
        check_eq("lui_ex_alu_ctr", 32'(alu_ctr), 32'd2);
        nc();
        check_eq("lui_wb_state", 32'(state), 32'd4);
        nc();

        // lw with dmem_ready low for 3 cycles: MEM held 4 cycles, 8 total
        dmem_ready = 1'b0;
        do_fetch(I_LW);
        nc();
        check_eq("lw_ex_ext_op", 32'(ext_op), 32'd1);
        check_eq("lw_ex_alu_src", 32'(alu_src), 32'd1);
        nc();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            check_eq("lw_mem_state", 32'(state), 32'd3);
            check_eq("lw_mem_dmem_req", 32'(dmem_req), 32'd1);
            check_eq("lw_mem_write", 32'(mem_write), 32'd0);
            @(negedge clk);
        end
        #1;
        check_eq("lw_wb_state", 32'(state), 32'd4);
        check_eq("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        check_eq("lw_wb_ext_op", 32'(ext_op), 32'd1);
        check_eq("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
        nc();
        check_eq("lw_done_state", 32'(state), 32'd0);

        // sw: MEM then straight back to IF
        do_fetch(I_SW);
        nc();
        nc();
        check_eq("sw_mem_write", 32'(mem_write), 32'd1);
        check_eq("sw_mem_reg_write", 32'(reg_write), 32'd0);
        nc();
        check_eq("sw_done_state", 32'(state), 32'd0);

        // beq taken and not taken: 3 cycles each
        for (int z = 1; z >= 0; z--) begin
            alu_zero = z[0];
            do_fetch(I_BEQ);
            check_eq("beq_id_state", 32'(state), 32'd1);
            nc();
            check_eq("beq_ex_state", 32'(state), 32'd2);
            check_eq("beq_ex_npc_sel", 32'(npc_sel), 32'd1);
            check_eq("beq_ex_pc_write", 32'(pc_write), 32'(z));
            check_eq("beq_ex_alu_ctr", 32'(alu_ctr), 32'd1);
            nc();
            check_eq("beq_done_state", 32'(state), 32'd0);
        end

        // jal
        do_fetch(I_JAL);
        check_eq("jal_pc_write", 32'(pc_write), 32'd1);
        check_eq("jal_npc_sel", 32'(npc_sel), 32'd2);
        check_eq("jal_reg_write", 32'(reg_write), 32'd1);
        check_eq("jal_reg_dst", 32'(reg_dst), 32'd2);
        check_eq("jal_mem_to_reg", 32'(mem_to_reg), 32'd2);
        nc();
        check_eq("jal_done_state", 32'(state), 32'd0);

        // j and jr
        do_fetch(I_J);
        check_eq("j_npc_sel", 32'(npc_sel), 32'd2);
        check_eq("j_reg_write", 32'(reg_write), 32'd0);
        nc();
        do_fetch(I_JR);
        check_eq("jr_npc_sel", 32'(npc_sel), 32'd3);
        check_eq("jr_pc_write", 32'(pc_write), 32'd1);
        nc();
        check_eq("jr_done_state", 32'(state), 32'd0);

        // imem_ready held low: bus_err every 15th cycle, state stays IF
        imem_ready = 1'b0;
        #1;
        for (int k = 1; k <= 32; k++) begin
            check_eq("to_bus_err", 32'(bus_err), 32'((k % 15) == 0));
            check_eq("to_ir_write", 32'(ir_write), 32'd0);
            check_eq("to_state", 32'(state), 32'd0);
            nc();
        end

        // Clear the counter with a fetch, then ready on the WAIT_MAX cycle wins
        do_fetch(I_J);
        nc();
        imem_ready = 1'b0;
        #1;
        for (int k = 1; k <= 14; k++) begin
            check_eq("rw_bus_err", 32'(bus_err), 32'd0);
            nc();
        end
        imem_ready = 1'b1;
        #1;
        check_eq("rw_bus_err_last", 32'(bus_err), 32'd0);
        check_eq("rw_ir_write", 32'(ir_write), 32'd1);
        nc();
        check_eq("rw_state", 32'(state), 32'd1);
        nc();

        // Reset during MEM of sw
        dmem_ready = 1'b0;
        do_fetch(I_SW);
        nc();
        nc();
        check_eq("rmem_mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rmem_mem_write_rst", 32'(mem_write), 32'd0);
        check_eq("rmem_dmem_req_rst", 32'(dmem_req), 32'd0);
        check_eq("rmem_state_rst", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check_eq("rmem_state_after", 32'(state), 32'd0);
        check_eq("rmem_mem_write_after", 32'(mem_write), 32'd0);
        check_eq("rmem_imem_req_after", 32'(imem_req), 32'd1);

        // Undefined opcode
        do_fetch(I_BAD);
        check_eq("bad_id_pc_write", 32'(pc_write), 32'd0);
        check_eq("bad_id_reg_write", 32'(reg_write), 32'd0);
        nc();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        check_eq("bad_trap_state", 32'(state), 32'd5);
        check_eq("bad_trap_imem_req", 32'(imem_req), 32'd0);
        nc();
        check_eq("bad_trap_hold", 32'(state), 32'd5);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("bad_trap_reset", 32'(state), 32'd0);
`else
        check_eq("bad_nop_state", 32'(state), 32'd0);
        check_eq("bad_nop_imem_req", 32'(imem_req), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control unit for the MIPS datapath: a registered FSM that sequences IF/ID/EX/MEM/WB and drives per-state datapath controls. It extends the single-cycle decoder set (addu, subu, ori, lw, sw, beq, jal) with lui, j and jr, uses ready/valid handshakes to instruction and data memory, and has a timeout. It sits between the IR/ALU-zero outputs and the PC, IR, register-file, ALU, extender and memory controls.

Parameters:
ALU_CTR_W, 3, width of alu_ctr; must be >=2; codes 0=addu, 1=subu, 2=or; others reserved.
WAIT_MAX, 15, maximum cycles to wait for imem_ready/dmem_ready before timeout; must be >=1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  IR contents, valid from ID onward
alu_zero  in  1  ALU zero flag, sampled in EX
imem_ready  in  1  instruction fetch data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
mem_write  out  1  data memory write (with dmem_req)
ir_write  out  1  latch IR
pc_write  out  1  update PC
npc_sel  out  2  0=PC+4, 1=branch target, 2=jump target {PC[31:28],imm26,00}, 3=rs (jr)
reg_write  out  1  register-file write
reg_dst  out  2  0=rt, 1=rd, 2=$31
alu_src  out  1  0=rt, 1=extended immediate
ext_op  out  2  0=zero-extend, 1=sign-extend, 2=imm<<16
mem_to_reg  out  2  0=ALU, 1=memory data, 2=PC+4
alu_ctr  out  ALU_CTR_W  ALU operation
bus_err  out  1  one-cycle pulse on handshake timeout
state  out  3  current FSM state (debug)

Behaviour:
- State register: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5 (TRAP only with the optional feature). It resets asynchronously to IF.
- All write/request outputs are combinational from state, opcode and funct. While rst_n=0 all of them are forced to 0, and npc_sel, reg_dst, ext_op, mem_to_reg, alu_ctr, bus_err and the wait counter are also 0.
- IF: imem_req=1. On imem_ready: ir_write=1, pc_write=1, npc_sel=0, then go to ID. Without imem_ready, stay in IF.
- ID (decode on instr[31:26], R-type funct on instr[5:0]):
  - j: pc_write=1, npc_sel=2, then IF.
  - jal: pc_write=1, npc_sel=2, reg_write=1, reg_dst=2, mem_to_reg=2, then IF.
  - jr (R, funct 001000): pc_write=1, npc_sel=3, then IF.
  - All others go to EX.
- EX, ALU and extender settings by instruction:
  - addu/subu: alu_src=0, alu_ctr=0/1.
  - ori: alu_src=1, ext_op=0, alu_ctr=2.
  - lui: alu_src=1, ext_op=2, alu_ctr=2.
  - lw/sw: alu_src=1, ext_op=1, alu_ctr=0.
  - beq: alu_src=0, ext_op=1, alu_ctr=1, npc_sel=1, pc_write=alu_zero, then IF.
- EX next state: lw/sw go to MEM; R-type, ori and lui go to WB.
- MEM: dmem_req=1, mem_write=1 for sw. On dmem_ready: lw goes to WB, sw goes to IF. Otherwise stay in MEM.
- WB: reg_write=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - ori/lui: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Then IF.
- EX and WB hold their ALU/extender selects so the datapath stays stable; the ALU result is registered by the datapath.
- Latency: j/jal/jr 2 cycles; beq 3; R/ori/lui/sw 4; lw 5. Each IF/MEM ready wait adds one cycle per wait cycle.
- Wait counter:
  - Counts consecutive IF/MEM cycles without ready; it clears on ready or on a state change.
  - When the count reaches WAIT_MAX without ready, bus_err pulses for one cycle and the counter clears.
  - The state is unchanged, so the request is retried. No write enable asserts on a timeout cycle.
- Ready arriving on the same cycle as WAIT_MAX: ready wins, with no bus_err.
- Ready asserted outside IF/MEM is ignored.
- Undefined opcode/funct without the optional feature: treated as NOP; ID goes to IF with no writes.
- Reset asserted mid-instruction: the FSM returns to IF immediately, and no partial write completes after reset is released.

Optional Feature:
MC_CTRL_ILLEGAL_TRAP_EN:
- Defined: an undefined opcode/funct in ID goes to TRAP. TRAP holds all enables at 0 and stays there until reset.
- Not defined: TRAP is unreachable and undefined instructions behave as NOP.

Test Plan:
- addu $3,$1,$2 (0x00221821), ready always 1 -> states IF,ID,EX,WB; in WB reg_write=1, reg_dst=1, alu_ctr=0; 4 cycles total.
- lw $2,4($1) (0x8C220004), dmem_ready low 3 cycles -> MEM held 4 cycles, dmem_req=1, mem_write=0; WB mem_to_reg=1, ext_op=1; 8 cycles total.
- beq $1,$2,off with alu_zero=1, then with alu_zero=0 -> in EX npc_sel=1 and pc_write=1 / 0; 3 cycles each.
- jal 0x0C000010 -> in ID pc_write=1, npc_sel=2, reg_write=1, reg_dst=2, mem_to_reg=2; back to IF after 2 cycles.
- imem_ready held 0 with WAIT_MAX=15 -> bus_err pulses at cycles 15, 30, ...; state stays IF; ir_write never asserts.
- Opcode 0x3F -> NOP back to IF (macro off), or TRAP with all enables 0 until rst_n pulse (macro on); rst_n low during MEM of sw -> mem_write drops to 0 asynchronously and state=IF.
